// File: rtl/dsm_dac_osr.sv
// dsm_dac_osr: order-1/2 single-bit delta-sigma DAC with a one-entry sample buffer and OSR-step zero-order hold
// ports: i_clk/i_rst (async, active-high), i_en step enable, i_valid/i_data/o_ready sample handshake,
//        o_dac_bitstream modulator bit, o_sample_tick frame boundary, o_underrun empty buffer at boundary,
//        o_sat integrator clamp on the last step
module dsm_dac_osr #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER = 2,
  parameter int OSR = 64,
  parameter int ACC_WIDTH = DATA_WIDTH + 6,
  parameter int FEEDBACK_MAG = 1 << (DATA_WIDTH - 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic                         o_dac_bitstream,
  output logic                         o_sample_tick,
  output logic                         o_underrun,
  output logic                         o_sat
);
  localparam int AW = ACC_WIDTH > DATA_WIDTH + 3 ? ACC_WIDTH : DATA_WIDTH + 3;
  localparam int CW = OSR > 2 ? $clog2(OSR) : 1;
  typedef logic signed [AW+1:0] wide_t;
  localparam wide_t HI = (wide_t'(1) <<< (AW - 1)) - wide_t'(1);
  localparam wide_t LO = -(wide_t'(1) <<< (AW - 1));
  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $fatal(1, "dsm_dac_osr: ORDER must be 1 or 2");
  end
  if (OSR < 2) begin : g_bad_osr
    $fatal(1, "dsm_dac_osr: OSR must be at least 2");
  end
  logic signed [AW-1:0] v1, v2, v1_n, v2_n;
  logic signed [DATA_WIDTH-1:0] x, buf_data;
  logic buf_valid, q, q_n, sat1, sat2, boundary;
  logic [CW-1:0] cnt;
  wide_t fb, s1, s2;
  assign o_ready = !buf_valid;
  assign o_dac_bitstream = q;
  assign boundary = cnt == CW'(OSR - 1);
  // sums are formed two bits wider than the integrators so clamping sees the true value
  always_comb begin
    fb = q ? wide_t'(FEEDBACK_MAG) : -wide_t'(FEEDBACK_MAG);
    s1 = wide_t'(v1) + wide_t'(x) - fb;
    s2 = wide_t'(v2) + wide_t'(v1) - (fb <<< 1);
    sat1 = s1 > HI || s1 < LO;
    sat2 = ORDER == 2 && (s2 > HI || s2 < LO);
    v1_n = s1 > HI ? HI[AW-1:0] : s1 < LO ? LO[AW-1:0] : s1[AW-1:0];
    v2_n = s2 > HI ? HI[AW-1:0] : s2 < LO ? LO[AW-1:0] : s2[AW-1:0];
    q_n = ORDER == 2 ? !v2_n[AW-1] : !v1_n[AW-1];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1 <= '0;
      x <= '0;
      buf_data <= '0;
      buf_valid <= 1'b0;
      cnt <= '0;
      q <= 1'b0;
      o_sample_tick <= 1'b0;
      o_underrun <= 1'b0;
      o_sat <= 1'b0;
    end else begin
      if (i_valid && !buf_valid) begin
        buf_data <= i_data;
        buf_valid <= 1'b1;
      end
      o_sample_tick <= i_en && boundary;
      o_underrun <= i_en && boundary && !buf_valid;
      o_sat <= i_en && (sat1 || sat2);
      if (i_en) begin
        v1 <= v1_n;
        q <= q_n;
        cnt <= boundary ? '0 : cnt + 1'b1;
        if (boundary && buf_valid) begin
          x <= buf_data;
          buf_valid <= 1'b0;
        end
      end
    end
  end
  if (ORDER == 2) begin : g_v2
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) v2 <= '0;
      else if (i_en) v2 <= v2_n;
    end
  end else begin : g_no_v2
    assign v2 = '0;
  end
endmodule
